n_way_set_lru: RTL and testbench
================================

Name: n_way_set_lru

Overview:
Parametrised successor of the fixed 4-way set: one set of a WAYS-way set-associative cache with its own tag/valid/dirty/data storage and true-LRU replacement. Accepts one request per cycle (read, write, fill, invalidate) and returns a registered response one cycle later. A fill that displaces a dirty line reports the evicted tag and data, so the cache controller can write it back.

Parameters:
ADDRESS_WORD_SIZE, 32, request address width
TAG_SIZE, 19, tag = address_word[ADDRESS_WORD_SIZE-1 -: TAG_SIZE]
DATA_WIDTH, 8, data stored per line
WAYS, 4, associativity; power of two, 2..16
IDX_W, $clog2(WAYS), way index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  request strobe, one request per cycle
req_op  in  2  00 READ, 01 WRITE, 10 FILL, 11 INVALIDATE
address_word  in  ADDRESS_WORD_SIZE  request address
write_data  in  DATA_WIDTH  data for WRITE/FILL
resp_valid  out  1  one-cycle pulse, response for the request of the previous cycle
hit_miss  out  1  1 = tag matched a valid way
hit_index  out  IDX_W  way hit, or way filled
data_out  out  DATA_WIDTH  line data after the operation
evict_valid  out  1  FILL displaced a valid dirty line
evict_tag  out  TAG_SIZE  tag of evicted line
evict_data  out  DATA_WIDTH  data of evicted line
valid_vec  out  WAYS  current valid bits (registered state)
dirty_vec  out  WAYS  current dirty bits (registered state)

Behaviour:
- Reset (async, rst_b=0): all valid/dirty/tag/data = 0; age[i] = i; every response output = 0.
- Lookup is combinational on address_word. Hit = valid & tag match. Ties are impossible by construction; if one occurs, the lowest index wins.
- All state updates and response outputs register on the rising clk edge when req_valid=1. resp_valid = registered req_valid, latency 1. Response outputs other than resp_valid hold their values until the next request.
- LRU: age[] is a permutation of 0..WAYS-1; 0 = MRU, WAYS-1 = LRU. Touch(k): every way with age < age[k] increments by 1; age[k] = 0.
- READ: on hit, data_out = line data and Touch(way). On miss, hit_miss=0, data_out=0, no state change.
- WRITE: on hit, data = write_data, dirty=1, Touch(way), data_out = write_data. On miss, no state change (the controller issues FILL, then WRITE).
- FILL, tag already present: overwrite data, dirty=0, Touch, evict_valid=0, hit_miss=1.
- FILL, tag absent: victim = lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
  - evict_valid = victim valid & dirty; evict_tag and evict_data = the old contents.
  - Install tag and data, valid=1, dirty=0, Touch(victim); hit_index = victim, hit_miss=0.
- INVALIDATE: on hit, valid=0 and dirty=0, ages unchanged, data_out = old data, hit_miss=1. On miss, no-op.
- evict_valid is 0 for every op except a FILL that evicts.
- req_valid=0: no state change; resp_valid=0 next cycle.
- Reset asserted mid-request: the request is discarded and no response is produced.

Optional Feature:
Macro SET_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - READ/WRITE requests increment one counter; FILL/INVALIDATE count in neither.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then READ addr 0x0000_2000 -> resp_valid next cycle, hit_miss=0, data_out=0, valid_vec=0.
- FILL four distinct tags T0..T3 with data 0x11..0x44 (WAYS=4) -> hit_index 0,1,2,3, evict_valid=0 each time, valid_vec=4'hF.
- READ T0 -> hit_miss=1, hit_index=0, data_out=0x11. Then FILL T4 -> victim way 1 (LRU), evict_valid=0 since clean.
- WRITE T2 with 0xA5 -> dirty_vec[2]=1. Touch ways 0,1,3, then FILL T5 -> hit_index=2, evict_valid=1, evict_tag=T2, evict_data=0xA5.
- INVALIDATE T3 -> valid_vec[3]=0. Next FILL T6 goes to way 3 regardless of ages.
- Assert rst_b low mid-request on a WRITE -> all outputs 0, no response pulse. With SET_STATS_EN defined, 70000 READ misses -> miss_count=16'hFFFF.

Source files
------------

// File: rtl/n_way_set_lru.sv
// n_way_set_lru: one set of a WAYS-way set-associative cache with true-LRU replacement and dirty eviction.
// Optional hit/miss counters are enabled by defining SET_STATS_EN.
module n_way_set_lru #(
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int TAG_SIZE          = 19,
    parameter int DATA_WIDTH        = 8,
    parameter int WAYS              = 4,
    localparam int IDX_W            = $clog2(WAYS)
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         req_valid,
    input  logic [1:0]                   req_op,
    input  logic [ADDRESS_WORD_SIZE-1:0] address_word,
    input  logic [DATA_WIDTH-1:0]        write_data,
    output logic                         resp_valid,
    output logic                         hit_miss,
    output logic [IDX_W-1:0]             hit_index,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         evict_valid,
    output logic [TAG_SIZE-1:0]          evict_tag,
    output logic [DATA_WIDTH-1:0]        evict_data,
`ifdef SET_STATS_EN
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count,
`endif
    output logic [WAYS-1:0]              valid_vec,
    output logic [WAYS-1:0]              dirty_vec
);
    localparam logic [1:0] OP_READ = 2'b00, OP_WRITE = 2'b01, OP_FILL = 2'b10, OP_INV = 2'b11;

    logic [TAG_SIZE-1:0]   tag_q  [WAYS], tag_d  [WAYS];
    logic [DATA_WIDTH-1:0] data_q [WAYS], data_d [WAYS];
    logic [IDX_W-1:0]      age_q  [WAYS], age_d  [WAYS];
    logic [WAYS-1:0]       valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_SIZE-1:0]   req_tag;
    logic                  hit, any_inv, touch;
    logic [IDX_W-1:0]      hit_way, inv_way, lru_way, victim, tw;
    logic                  hit_miss_d, evict_valid_d;
    logic [IDX_W-1:0]      hit_index_d;
    logic [DATA_WIDTH-1:0] data_out_d, evict_data_d;
    logic [TAG_SIZE-1:0]   evict_tag_d;

    assign req_tag   = address_word[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
    assign valid_vec = valid_q;
    assign dirty_vec = dirty_q;
    assign victim    = any_inv ? inv_way : lru_way;

    // Descending scans so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit     = 1'b1;
                hit_way = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                any_inv = 1'b1;
                inv_way = IDX_W'(i);
            end
            if (age_q[i] == IDX_W'(WAYS - 1)) lru_way = IDX_W'(i);
        end
    end

    always_comb begin
        tag_d         = tag_q;
        data_d        = data_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        age_d         = age_q;
        touch         = 1'b0;
        tw            = hit_way;
        hit_miss_d    = hit;
        hit_index_d   = hit ? hit_way : '0;
        data_out_d    = '0;
        evict_valid_d = 1'b0;
        evict_tag_d   = '0;
        evict_data_d  = '0;
        unique case (req_op)
            OP_READ: if (hit) begin
                data_out_d = data_q[hit_way];
                touch      = 1'b1;
            end
            OP_WRITE: if (hit) begin
                data_d[hit_way]  = write_data;
                dirty_d[hit_way] = 1'b1;
                data_out_d       = write_data;
                touch            = 1'b1;
            end
            OP_FILL: if (hit) begin
                data_d[hit_way]  = write_data;
                dirty_d[hit_way] = 1'b0;
                data_out_d       = write_data;
                touch            = 1'b1;
            end else begin
                tw              = victim;
                hit_index_d     = victim;
                evict_valid_d   = valid_q[victim] & dirty_q[victim];
                evict_tag_d     = tag_q[victim];
                evict_data_d    = data_q[victim];
                tag_d[victim]   = req_tag;
                data_d[victim]  = write_data;
                valid_d[victim] = 1'b1;
                dirty_d[victim] = 1'b0;
                data_out_d      = write_data;
                touch           = 1'b1;
            end
            OP_INV: if (hit) begin
                valid_d[hit_way] = 1'b0;
                dirty_d[hit_way] = 1'b0;
                data_out_d       = data_q[hit_way];
            end
            default: ;
        endcase
        // Touch: ways younger than the touched one age by one, touched way becomes MRU.
        if (touch)
            for (int i = 0; i < WAYS; i++)
                age_d[i] = (IDX_W'(i) == tw) ? '0 :
                           (age_q[i] < age_q[tw]) ? age_q[i] + IDX_W'(1) : age_q[i];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < WAYS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= IDX_W'(i);
            end
            valid_q     <= '0;
            dirty_q     <= '0;
            resp_valid  <= 1'b0;
            hit_miss    <= 1'b0;
            hit_index   <= '0;
            data_out    <= '0;
            evict_valid <= 1'b0;
            evict_tag   <= '0;
            evict_data  <= '0;
        end else begin
            resp_valid <= req_valid;
            if (req_valid) begin
                tag_q       <= tag_d;
                data_q      <= data_d;
                age_q       <= age_d;
                valid_q     <= valid_d;
                dirty_q     <= dirty_d;
                hit_miss    <= hit_miss_d;
                hit_index   <= hit_index_d;
                data_out    <= data_out_d;
                evict_valid <= evict_valid_d;
                evict_tag   <= evict_tag_d;
                evict_data  <= evict_data_d;
            end
        end
    end

`ifdef SET_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Only READ/WRITE (op[1]==0) are counted; both counters saturate.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (req_valid && !req_op[1]) begin
            if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_n_way_set_lru.sv
// tb_n_way_set_lru: randomized + directed scoreboard bench for n_way_set_lru against a recency-list model.
module tb_n_way_set_lru;
    localparam int AW = 32, TW = 19, DW = 8, W = 4;

    logic clk = 0, rst_b = 0, req_valid = 0;
    logic [1:0] req_op = 0;
    logic [AW-1:0] address_word = 0;
    logic [DW-1:0] write_data = 0;
    logic resp_valid, hit_miss, evict_valid;
    logic [1:0] hit_index;
    logic [DW-1:0] data_out, evict_data;
    logic [TW-1:0] evict_tag;
    logic [W-1:0] valid_vec, dirty_vec;
`ifdef SET_STATS_EN
    logic [15:0] hit_count, miss_count;
    int exp_hits = 0, exp_misses = 0;
`endif

    n_way_set_lru dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_op(req_op),
        .address_word(address_word), .write_data(write_data),
        .resp_valid(resp_valid), .hit_miss(hit_miss), .hit_index(hit_index),
        .data_out(data_out), .evict_valid(evict_valid), .evict_tag(evict_tag),
        .evict_data(evict_data),
`ifdef SET_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .valid_vec(valid_vec), .dirty_vec(dirty_vec));

    always #5 clk = ~clk;

    typedef struct {
        int due; bit hm; bit ci; int idx; bit cd; logic [DW-1:0] data;
        bit ev; logic [TW-1:0] et; logic [DW-1:0] ed; logic [W-1:0] vv, dv;
    } exp_t;

    exp_t sb[$];
    int cyc = 0, total = 0, passed = 0;
    bit mv[W], md[W];
    logic [TW-1:0] mt[W];
    logic [DW-1:0] mdat[W];
    int rec[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        else passed++;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < W; i++) begin mv[i] = 0; md[i] = 0; mt[i] = 0; mdat[i] = 0; end
        rec = {0, 1, 2, 3};
`ifdef SET_STATS_EN
        exp_hits = 0; exp_misses = 0;
`endif
    endfunction

    function automatic void touch(int w);
        int p[$];
        p = rec.find_first_index(x) with (x == w);
        rec.delete(p[0]);
        rec.push_front(w);
    endfunction

    task automatic issue(input logic [1:0] op, input logic [TW-1:0] tag, input logic [DW-1:0] wd);
        exp_t e;
        int hw;
        @(posedge clk); #1;
        req_valid = 1; req_op = op; write_data = wd;
        address_word = {tag, 13'($urandom)};
        hw = -1;
        for (int i = 0; i < W; i++) if (hw < 0 && mv[i] && mt[i] == tag) hw = i;
        e = '{due: cyc + 1, hm: hw >= 0, ci: hw >= 0, idx: hw, cd: 0, data: 0,
              ev: 0, et: 0, ed: 0, vv: 0, dv: 0};
        case (op)
            2'b00: begin e.cd = 1; if (hw >= 0) begin e.data = mdat[hw]; touch(hw); end end
            2'b01: if (hw >= 0) begin mdat[hw] = wd; md[hw] = 1; touch(hw); e.cd = 1; e.data = wd; end
            2'b10: if (hw >= 0) begin
                mdat[hw] = wd; md[hw] = 0; touch(hw); e.cd = 1; e.data = wd;
            end else begin
                int v = -1;
                for (int i = 0; i < W; i++) if (v < 0 && !mv[i]) v = i;
                if (v < 0) v = rec[$];
                e.ci = 1; e.idx = v; e.ev = mv[v] && md[v]; e.et = mt[v]; e.ed = mdat[v];
                mt[v] = tag; mdat[v] = wd; mv[v] = 1; md[v] = 0; touch(v);
                e.cd = 1; e.data = wd;
            end
            default: if (hw >= 0) begin e.cd = 1; e.data = mdat[hw]; mv[hw] = 0; md[hw] = 0; end
        endcase
        for (int i = 0; i < W; i++) begin e.vv[i] = mv[i]; e.dv[i] = md[i]; end
`ifdef SET_STATS_EN
        if (!op[1]) begin
            if (hw >= 0) exp_hits = (exp_hits < 65535) ? exp_hits + 1 : 65535;
            else exp_misses = (exp_misses < 65535) ? exp_misses + 1 : 65535;
        end
`endif
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic settle();
        idle();
        @(negedge clk);
    endtask

    exp_t m;
    always @(negedge clk) if (rst_b) begin
        if (resp_valid) begin
            if (sb.size() == 0 || sb[0].due != cyc) check("spurious_resp", resp_valid, 1'b0);
            else begin
                m = sb.pop_front();
                check("hit_miss", hit_miss, m.hm);
                if (m.ci) check("hit_index", hit_index, m.idx);
                if (m.cd) check("data_out", data_out, m.data);
                check("evict_valid", evict_valid, m.ev);
                if (m.ev) begin
                    check("evict_tag", evict_tag, m.et);
                    check("evict_data", evict_data, m.ed);
                end
                check("valid_vec", valid_vec, m.vv);
                check("dirty_vec", dirty_vec, m.dv);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("missing_resp", resp_valid, 1'b1);
            void'(sb.pop_front());
        end
    end

    task automatic check_zero(string n);
        check({n, "_resp_valid"}, resp_valid, 0);
        check({n, "_hit_miss"}, hit_miss, 0);
        check({n, "_hit_index"}, hit_index, 0);
        check({n, "_data_out"}, data_out, 0);
        check({n, "_evict"}, {evict_valid, evict_tag, evict_data}, 0);
        check({n, "_valid_vec"}, valid_vec, 0);
        check({n, "_dirty_vec"}, dirty_vec, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    localparam logic [TW-1:0] T0 = 19'd10;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_b = 1;

        issue(2'b00, 19'd1, 8'h00);
        settle();
        check("empty_read_hit", hit_miss, 0);
        check("empty_read_data", data_out, 0);
        check("empty_read_vv", valid_vec, 0);

        for (int k = 0; k < 4; k++) issue(2'b10, T0 + 19'(k), 8'(8'h11 * (k + 1)));
        settle();
        check("fill4_vv", valid_vec, 4'hF);
        check("fill4_last_idx", hit_index, 3);

        issue(2'b00, T0, 8'h00);
        issue(2'b10, T0 + 19'd4, 8'h55);
        settle();
        check("lru_victim_idx", hit_index, 1);
        check("lru_victim_clean", evict_valid, 0);

        issue(2'b01, T0 + 19'd2, 8'hA5);
        settle();
        check("write_dirty2", dirty_vec[2], 1);

        issue(2'b00, T0, 8'h00);
        issue(2'b00, T0 + 19'd4, 8'h00);
        issue(2'b00, T0 + 19'd3, 8'h00);
        issue(2'b10, T0 + 19'd5, 8'h66);
        settle();
        check("dirty_evict_idx", hit_index, 2);
        check("dirty_evict_valid", evict_valid, 1);
        check("dirty_evict_tag", evict_tag, T0 + 19'd2);
        check("dirty_evict_data", evict_data, 8'hA5);

        issue(2'b11, T0 + 19'd3, 8'h00);
        settle();
        check("inv_vv3", valid_vec[3], 0);
        issue(2'b10, T0 + 19'd6, 8'h77);
        settle();
        check("fill_invalid_way", hit_index, 3);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else issue(2'($urandom), 19'd100 + 19'($urandom_range(0, 6)), 8'($urandom));
        end
        settle();
`ifdef SET_STATS_EN
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
`endif

        repeat (2) idle();
        @(posedge clk); #1;
        req_valid = 1; req_op = 2'b01; address_word = {19'd100, 13'd0}; write_data = 8'h5A;
        #2 rst_b = 0;
        @(negedge clk);
        req_valid = 0;
        check_zero("midreset");
`ifdef SET_STATS_EN
        check("midreset_hits", hit_count, 0);
        check("midreset_misses", miss_count, 0);
`endif
        model_reset();
        @(posedge clk); #3 rst_b = 1;

        for (int n = 0; n < 150; n++) issue(2'($urandom), 19'd200 + 19'($urandom_range(0, 5)), 8'($urandom));
        settle();

`ifdef SET_STATS_EN
        for (int n = 0; n < 70000; n++) issue(2'b00, 19'h7FFFF, 8'h00);
        settle();
        check("sat_miss_count", miss_count, 16'hFFFF);
        check("sat_hit_count", hit_count, exp_hits);
`endif

        repeat (3) idle();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
